// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  // Fetch sequencer states: present address, await cache, hold while queue is full.
  typedef enum logic [1:0] {
    StSettle = 2'd0,
    StWait   = 2'd1,
    StFull   = 2'd2
  } ifu_state_t;

  // One buffered fetch: the PC it came from and the returned instruction word.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int unsigned INSTR_BYTES = 4;

  // Force an address onto a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Instruction FIFO for the fetch unit. Pointers carry one extra MSB so that
// full and empty are distinguished without a separate occupancy counter.
// Flush empties the queue in one cycle; the head reads as all-zero when empty.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int unsigned Depth   = 4,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   flush_i,
  input  logic   push_i,
  input  entry_t entry_i,
  input  logic   pop_i,
  output logic   full_o,
  output logic   empty_o,
  output entry_t head_o
);

  localparam int unsigned Aw = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Aw:0]   wr_ptr_q, wr_ptr_d;
  logic [Aw:0]   rd_ptr_q, rd_ptr_d;
  logic [Aw-1:0] wr_idx, rd_idx;
  logic          push_en, pop_en;
  entry_t        mem_q [Depth];

  assign wr_idx = wr_ptr_q[Aw-1:0];
  assign rd_idx = rd_ptr_q[Aw-1:0];

  // Full/empty decode and accepted push/pop; a push into a full queue only
  // proceeds when the head is leaving in the same cycle.
  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[Aw] != rd_ptr_q[Aw]) && (wr_idx == rd_idx);
    pop_en   = pop_i && !empty_o;
    push_en  = push_i && (!full_o || pop_en);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + (Aw + 1)'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + (Aw + 1)'(1);
    end
  end

  // Pointer registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk_i) begin
    if (rst_ni && push_en && !flush_i) begin
      mem_q[wr_idx] <= entry_i;
    end
  end

  // Head presentation; zero while empty so idle outputs are deterministic.
  always_comb begin
    head_o = '0;
    if (!empty_o) head_o = mem_q[rd_idx];
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: walks a sequential PC, presents it to the cache CPU
// port, queues returned words with their PC and hands them to decode over a
// valid/ready handshake. A redirect flushes everything and restarts at the
// target. Optional performance counters are enabled with IFU_PERF_EN.
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  output logic [31:0] fetch_addr,
  input  logic [31:0] fetch_data,
  input  logic        fetch_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        fetch_busy
`ifdef IFU_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  ifu_state_t   state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         push, pop;
  logic         fifo_full, fifo_empty;
  fetch_entry_t push_entry, head;

  // Next-state, PC advance and push decision. The first cycle of a new
  // address (StSettle) ignores fetch_ready because the cache's ready may
  // still belong to the previous address. Redirect overrides everything.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    unique case (state_q)
      StSettle: state_d = StWait;
      StWait: begin
        if (fetch_ready) begin
          if (!fifo_full) begin
            push    = 1'b1;
            pc_d    = pc_q + 32'(INSTR_BYTES);
            state_d = StSettle;
          end else begin
            state_d = StFull;
          end
        end
      end
      StFull: begin
        // Occupancy is the registered view, so a pop this cycle only frees
        // the slot for next cycle's decision.
        if (!fifo_full) state_d = StSettle;
      end
      default: state_d = StSettle;
    endcase
    if (redirect_valid) begin
      state_d = StSettle;
      pc_d    = align_pc(redirect_pc);
      push    = 1'b0;
    end
  end

  // Sequencer state and fetch PC registers.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= StSettle;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Entry formation and decode-side pop; a redirect cycle discards the pop.
  always_comb begin
    push_entry.pc    = pc_q;
    push_entry.instr = fetch_data;
    pop              = !fifo_empty && instr_ready && !redirect_valid;
  end

  ifu_fifo #(
    .Depth   (QUEUE_DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk_i   (HCLK),
    .rst_ni  (HRESETn),
    .flush_i (redirect_valid),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head)
  );

  // Output mapping.
  always_comb begin
    fetch_addr  = pc_q;
    fetch_busy  = (state_q == StWait);
    instr_valid = !fifo_empty;
    instr_data  = head.instr;
    instr_pc    = head.pc;
  end

`ifdef IFU_PERF_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;
  logic        stall_inc;

  // A stall is a WAIT cycle without data or any cycle blocked on a full queue.
  always_comb begin
    stall_inc = ((state_q == StWait) && !fetch_ready) || (state_q == StFull);
  end

  // Saturating counters, cleared only by reset (redirects leave them alone).
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (push && (fetch_cnt_q != 32'hFFFF_FFFF)) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (stall_inc && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit. A stream model predicts the
// delivered PC/data sequence (sequential from reset or redirect target, data
// = pc ^ key), checked at every handshake; directed tests pin timing.
module tb_instruction_fetch_unit;

  localparam logic [31:0] Key = 32'hA5A5_A5A5;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_data;
  logic        fetch_ready;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        fetch_busy;
`ifdef IFU_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_deliv  = 0;

  instruction_fetch_unit #(
    .QUEUE_DEPTH (4),
    .RESET_PC    (32'h0000_0000)
  ) dut (
    .HCLK           (HCLK),
    .HRESETn        (HRESETn),
    .fetch_addr     (fetch_addr),
    .fetch_data     (fetch_data),
    .fetch_ready    (fetch_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .fetch_busy     (fetch_busy)
`ifdef IFU_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 HCLK = ~HCLK;

  // Cache model: hit mode keeps ready high permanently (including across
  // address changes); miss mode answers in the 6th WAIT cycle.
  logic        miss_mode = 1'b0;
  int unsigned wait_cnt  = 0;
  always @(posedge HCLK) wait_cnt <= fetch_busy ? wait_cnt + 1 : 0;
  assign fetch_ready = miss_mode ? (fetch_busy && (wait_cnt == 5)) : 1'b1;
  assign fetch_data  = fetch_addr ^ Key;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic wait_valid(input int unsigned budget);
    int unsigned n = 0;
    while (!instr_valid && n < budget) begin
      tick();
      n++;
    end
    check32("wait_instr_valid", {31'b0, instr_valid}, 32'd1);
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    tick();
    tick();
    HRESETn = 1'b1;
  endtask

  task automatic check_reset_values();
    check32("rst_fetch_addr", fetch_addr, 32'h0);
    check32("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check32("rst_instr_data", instr_data, 32'h0);
    check32("rst_instr_pc", instr_pc, 32'h0);
    check32("rst_fetch_busy", {31'b0, fetch_busy}, 32'd0);
`ifdef IFU_PERF_EN
    check32("rst_perf_fetch", perf_fetch_cnt, 32'h0);
    check32("rst_perf_stall", perf_stall_cnt, 32'h0);
`endif
  endtask

  // Stream model and compare process, sampled mid-cycle.
  logic [31:0] exp_pc = 32'h0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_pc, prev_data;
  always @(negedge HCLK) begin
    if (!HRESETn) begin
      exp_pc     = 32'h0;
      prev_stall = 1'b0;
    end else begin
      check32("fetch_addr_aligned", {30'b0, fetch_addr[1:0]}, 32'h0);
      if (prev_stall) begin
        check32("head_hold_valid", {31'b0, instr_valid}, 32'd1);
        check32("head_hold_pc", instr_pc, prev_pc);
        check32("head_hold_data", instr_data, prev_data);
      end
      if (redirect_valid) begin
        exp_pc     = redirect_pc & 32'hFFFF_FFFC;
        prev_stall = 1'b0;
      end else if (instr_valid && instr_ready) begin
        check32("stream_pc", instr_pc, exp_pc);
        check32("stream_data", instr_data, exp_pc ^ Key);
        exp_pc     = exp_pc + 32'd4;
        n_deliv++;
        prev_stall = 1'b0;
      end else begin
        prev_stall = instr_valid;
        prev_pc    = instr_pc;
        prev_data  = instr_data;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    int unsigned base;
    int unsigned n;

    // Reset values, then always-hit stream with decode always ready.
    instr_ready = 1'b1;
    HRESETn = 1'b0;
    tick();
    tick();
    check_reset_values();
    HRESETn = 1'b1;
    tick();  // SETTLE ended; stale-high ready must not have pushed
    check32("t1_busy_wait", {31'b0, fetch_busy}, 32'd1);
    check32("t1_no_settle_push", {31'b0, instr_valid}, 32'd0);
    check32("t1_addr0", fetch_addr, 32'h0);
    tick();
    check32("t1_valid0", {31'b0, instr_valid}, 32'd1);
    check32("t1_pc0", instr_pc, 32'h0);
    check32("t1_data0", instr_data, 32'hA5A5_A5A5);
    check32("t1_addr4", fetch_addr, 32'h4);
    tick();
    check32("t1_popped", {31'b0, instr_valid}, 32'd0);
    tick();
    check32("t1_pc4", instr_pc, 32'h4);
    check32("t1_data4", instr_data, 32'hA5A5_A5A1);
    tick();
    tick();
    check32("t1_pc8", instr_pc, 32'h8);
    check32("t1_data8", instr_data, 32'hA5A5_A5AD);
    check32("t1_addrC", fetch_addr, 32'hC);
    repeat (10) tick();

    // Decode stalled: queue fills, sequencer parks in FULL at 0x10.
    instr_ready = 1'b0;
    do_reset();
    repeat (12) tick();
    check32("t2_full_addr", fetch_addr, 32'h10);
    check32("t2_full_notbusy", {31'b0, fetch_busy}, 32'd0);
    check32("t2_head_pc", instr_pc, 32'h0);
`ifdef IFU_PERF_EN
    check32("t2_perf_fetch", perf_fetch_cnt, 32'd4);
    check32("t2_perf_stall", perf_stall_cnt, 32'd2);
`endif
    base = n_deliv;
    instr_ready = 1'b1;
    repeat (30) tick();
    check32("t2_progress", {31'b0, (n_deliv - base) >= 12}, 32'd1);

    // Miss model: six busy cycles per fetch, one delivery per address.
    instr_ready = 1'b1;
    miss_mode = 1'b1;
    do_reset();
    base = n_deliv;
    for (int f = 0; f < 2; f++) begin
      n = 0;
      while (!fetch_busy && n < 10) begin
        tick();
        n++;
      end
      n = 0;
      while (fetch_busy && n < 20) begin
        n++;
        tick();
      end
      check32("t3_busy_cycles", n, 32'd6);
    end
    tick();
    check32("t3_deliveries", n_deliv - base, 32'd2);
`ifdef IFU_PERF_EN
    check32("t3_perf_fetch", perf_fetch_cnt, 32'd2);
    check32("t3_perf_stall", perf_stall_cnt, 32'd10);
`endif
    miss_mode = 1'b0;

    // Redirect with three queued entries and a hit pending in WAIT.
    instr_ready = 1'b0;
    do_reset();
    repeat (7) tick();
    check32("t4_in_wait", {31'b0, fetch_busy}, 32'd1);
    check32("t4_head_pc", instr_pc, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_1003;
    tick();
    redirect_valid = 1'b0;
    check32("t4_flushed", {31'b0, instr_valid}, 32'd0);
    check32("t4_target_addr", fetch_addr, 32'h1000);
    instr_ready = 1'b1;
    wait_valid(10);
    check32("t4_first_pc", instr_pc, 32'h1000);
    check32("t4_first_data", instr_data, 32'h1000 ^ Key);
    repeat (6) tick();

    // Address wrap: 0xFFFF_FFFC is followed by 0x0.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    wait_valid(10);
    check32("t5_top_pc", instr_pc, 32'hFFFF_FFFC);
    tick();
    wait_valid(10);
    check32("t5_wrap_pc", instr_pc, 32'h0);
    check32("t5_wrap_data", instr_data, Key);
    repeat (4) tick();

    // Reset while FULL.
    instr_ready = 1'b0;
    do_reset();
    repeat (12) tick();
    check32("t6_full_addr", fetch_addr, 32'h10);
    HRESETn = 1'b0;
    tick();
    check_reset_values();
    HRESETn = 1'b1;
    instr_ready = 1'b1;
    repeat (8) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
